mem_port_arbiter: RTL and testbench

Shares one single-port synchronous data memory between two requesters: the CPU load/store port (cpu_*) and a debug/program-loader port (dbg_*). The loader streams addr/data words into memory while the CPU runs or is stalled. The block sits between the singleCycleCpu data-memory interface and the memory macro. It arbitrates with a round-robin policy, sequences each access through a small FSM and returns read data after a fixed memory latency.

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/rr_arb2.sv | 15 +
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state type, port ids and latency-counter width shared by mem_port_arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  // Counter is sized for the largest legal latency so every build shares one width.
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_W = $clog2(MEM_LAT_MAX + 1);
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way picker; the port that did not win last takes a tie unless dbg has priority.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio_dbg,
  output logic       valid,
  output logic       winner
);
  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? (prio_dbg ? PORT_DBG : ~last) : req[PORT_DBG];
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port data memory between the CPU and a debug/loader port.
// Define ARB_DBG_PRIO_EN to give the dbg port strict priority on ties instead of round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  sys_rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
`ifdef ARB_DBG_PRIO_EN
  localparam logic PRIO_DBG = 1'b1;
`else
  localparam logic PRIO_DBG = 1'b0;
`endif
  state_e                state_q, state_d;
  logic [LAT_W-1:0]      cnt_q, cnt_d;
  logic                  owner_q, rr_last_q, we_q, mem_en_q, mem_we_q;
  logic [1:0]            gnt_q, rvalid_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic                  arb_valid, arb_winner;

  rr_arb2 u_arb (
    .req      ({dbg_req, cpu_req}),
    .last     (rr_last_q),
    .prio_dbg (PRIO_DBG),
    .valid    (arb_valid),
    .winner   (arb_winner)
  );

  // Any unreachable encoding falls back to IDLE.
  always_comb begin
    state_d = (state_q == IDLE)  ? (arb_valid ? ISSUE : IDLE) :
              (state_q == ISSUE) ? (we_q ? IDLE : WAIT) :
              (state_q == WAIT && cnt_q != '0) ? WAIT : IDLE;
    cnt_d   = (state_q == ISSUE) ? LAT_W'(MEM_LAT - 1) :
              (state_q == WAIT && cnt_q != '0) ? cnt_q - LAT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= PORT_CPU;
      rr_last_q   <= PORT_DBG;
      we_q        <= 1'b0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= '0;
      rvalid_q <= '0;
      mem_en_q <= state_q == ISSUE;
      mem_we_q <= state_q == ISSUE && we_q;
      if (state_q == IDLE && arb_valid) begin
        gnt_q[arb_winner] <= 1'b1;
        owner_q           <= arb_winner;
        rr_last_q         <= arb_winner;
        we_q              <= arb_winner ? dbg_we : cpu_we;
        mem_addr_q        <= arb_winner ? dbg_addr : cpu_addr;
        mem_wdata_q       <= arb_winner ? dbg_wdata : cpu_wdata;
      end
      if (state_q == WAIT && cnt_q == '0) begin
        rvalid_q[owner_q] <= 1'b1;
        rdata_q[owner_q]  <= mem_rdata;
      end
    end
  end

  assign cpu_gnt    = gnt_q[PORT_CPU];
  assign dbg_gnt    = gnt_q[PORT_DBG];
  assign cpu_rvalid = rvalid_q[PORT_CPU];
  assign dbg_rvalid = rvalid_q[PORT_DBG];
  assign cpu_rdata  = rdata_q[PORT_CPU];
  assign dbg_rdata  = rdata_q[PORT_DBG];
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random traffic against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LAT = 3;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          sys_rst_n = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dbg_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dbg_wdata = '0;
  logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we;
  logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LAT(LAT)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory macro: read data is presented LAT-1 cycles after the mem_en cycle, garbage otherwise.
  bit [DW-1:0] tb_mem [64];
  int          age;
  logic        rd_ok;
  always @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) age <= 0;
    else begin
      if (mem_en && mem_we) tb_mem[mem_addr[5:0]] <= mem_wdata;
      age <= (mem_en && !mem_we) ? 1 : (age != 0 && age < LAT - 1) ? age + 1 : 0;
    end
  end
  assign rd_ok     = (LAT == 1) ? (mem_en && !mem_we) : (age == LAT - 1);
  assign mem_rdata = rd_ok ? tb_mem[mem_addr[5:0]] : 32'hBAD0_BAD0;

  txn_t          q_c[$], q_d[$];
  bit [DW-1:0]   ref_mem [64];
  int            k, next_ok, g_t, e_t, r_t, n_chk, n_fail, n_dgnt;
  logic          g_p, r_p, last, e_we;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_d, r_d;
  logic [DW-1:0] exp_rd [2];
  logic [7:0]    gseq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    cpu_req = q_c.size() != 0;
    dbg_req = q_d.size() != 0;
    if (cpu_req) begin cpu_we = q_c[0].we; cpu_addr = q_c[0].addr; cpu_wdata = q_c[0].data; end
    if (dbg_req) begin dbg_we = q_d[0].we; dbg_addr = q_d[0].addr; dbg_wdata = q_d[0].data; end
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    q_c.delete();
    q_d.delete();
    drive();
    g_t = -1; e_t = -1; r_t = -1; next_ok = 0; last = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_gnt", {cpu_gnt, dbg_gnt}, 0);
    chk("rst_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
    #1 sys_rst_n = 1'b1;
  endtask

  // One clock: the model decides the edge's outcome from the requests presented before it.
  task automatic tick();
    logic rc, rd, p;
    txn_t t;
    rc = cpu_req;
    rd = dbg_req;
    @(posedge clk);
    k++;
    if (k >= next_ok && (rc || rd)) begin
`ifdef ARB_DBG_PRIO_EN
      p = rd;
`else
      p = (rc && rd) ? !last : rd;
`endif
      t = p ? q_d[0] : q_c[0];
      last = p; g_t = k; g_p = p; e_t = k + 1; e_we = t.we; e_a = t.addr; e_d = t.data;
      if (t.we) begin
        ref_mem[t.addr[5:0]] = t.data;
        next_ok = k + 2;
      end else begin
        r_t = k + 1 + LAT; r_p = p; r_d = ref_mem[t.addr[5:0]];
        next_ok = k + 2 + LAT;
      end
    end
    if (k == r_t) exp_rd[r_p] = r_d;
    #1;
    chk("cpu_gnt", cpu_gnt, k == g_t && !g_p);
    chk("dbg_gnt", dbg_gnt, k == g_t && g_p);
    chk("cpu_rvalid", cpu_rvalid, k == r_t && !r_p);
    chk("dbg_rvalid", dbg_rvalid, k == r_t && r_p);
    chk("mem_en", mem_en, k == e_t);
    chk("mem_we", mem_we, k == e_t && e_we);
    if (k == e_t) chk("mem_addr", mem_addr, e_a);
    if (k == e_t && e_we) chk("mem_wdata", mem_wdata, e_d);
    chk("cpu_rdata", cpu_rdata, exp_rd[0]);
    chk("dbg_rdata", dbg_rdata, exp_rd[1]);
    if (cpu_gnt || dbg_gnt) gseq = {gseq[6:0], dbg_gnt};
    if (dbg_gnt) n_dgnt++;
    if (cpu_gnt && q_c.size() != 0) void'(q_c.pop_front());
    if (dbg_gnt && q_d.size() != 0) void'(q_d.pop_front());
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q_c.size() != 0 || q_d.size() != 0 || k < next_ok) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_budget", n < budget, 1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; k = 0; gseq = '0; n_dgnt = 0;
    #1 apply_reset();
    repeat (10) tick();

    q_d.push_back('{we: 1'b1, addr: 32'h10, data: 32'hDEADBEEF});
    q_d.push_back('{we: 1'b0, addr: 32'h10, data: 32'h0});
    drive();
    drain(50);
    chk("dbg_read_0x10", dbg_rdata, 32'hDEADBEEF);

    gseq = '0;
    q_c.push_back('{we: 1'b1, addr: 32'h20, data: 32'h12345678});
    q_c.push_back('{we: 1'b0, addr: 32'h10, data: 32'h0});
    q_d.push_back('{we: 1'b1, addr: 32'h30, data: 32'hA5A5A5A5});
    q_d.push_back('{we: 1'b0, addr: 32'h20, data: 32'h0});
    drive();
    drain(100);
`ifdef ARB_DBG_PRIO_EN
    chk("tie_order", gseq[3:0], 4'b1100);
`else
    chk("tie_order", gseq[3:0], 4'b0101);
`endif

    q_c.push_back('{we: 1'b0, addr: 32'h20, data: 32'h0});
    drive();
    for (int i = 0; i < 10 && !cpu_gnt; i++) tick();
    chk("wait_cpu_gnt", cpu_gnt, 1);
    tick();
    q_d.push_back('{we: 1'b0, addr: 32'h30, data: 32'h0});
    drive();
    drain(50);
    chk("cpu_read_0x20", cpu_rdata, 32'h12345678);
    chk("dbg_read_0x30", dbg_rdata, 32'hA5A5A5A5);

    q_c.push_back('{we: 1'b0, addr: 32'h10, data: 32'h0});
    drive();
    for (int i = 0; i < 10 && !cpu_gnt; i++) tick();
    chk("wait_cpu_gnt2", cpu_gnt, 1);
    tick();
    chk("mem_en_before_rst", mem_en, 1);
    apply_reset();
    repeat (8) tick();
    gseq = '0;
    q_c.push_back('{we: 1'b1, addr: 32'h3, data: 32'h33});
    q_d.push_back('{we: 1'b1, addr: 32'h4, data: 32'h44});
    drive();
    drain(50);
`ifdef ARB_DBG_PRIO_EN
    chk("post_rst_tie", gseq[1:0], 2'b10);
`else
    chk("post_rst_tie", gseq[1:0], 2'b01);
`endif

    n_dgnt = 0;
    for (int i = 0; i < 16; i++) q_d.push_back('{we: 1'b1, addr: AW'(i), data: DW'(i)});
    drive();
    drain(100);
    chk("stream_gnt_count", n_dgnt, 16);
    for (int i = 0; i < 16; i++) q_d.push_back('{we: 1'b0, addr: AW'(i), data: '0});
    drive();
    drain(200);
    chk("stream_last_rdata", dbg_rdata, 15);

    repeat (400) begin
      if (q_c.size() < 2 && $urandom_range(0, 3) == 0)
        q_c.push_back('{we: 1'($urandom_range(0, 1)), addr: AW'($urandom_range(0, 63)), data: DW'($urandom)});
      if (q_d.size() < 2 && $urandom_range(0, 3) == 0)
        q_d.push_back('{we: 1'($urandom_range(0, 1)), addr: AW'($urandom_range(0, 63)), data: DW'($urandom)});
      drive();
      tick();
    end
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
